// File: rtl/e_tb_ctrl_213_if.sv
// Survivor-memory and decoded-bit bundle for the (2,1,3) Viterbi traceback
// controller; master is the controller, slave is its environment.
interface e_tb_ctrl_213_if #(
  parameter int M  = 3,
  parameter int AW = 6
);
  logic            acs_valid;
  logic [M-1:0]    min_state;
  logic            surv_wr_en;
  logic [AW-1:0]   surv_wr_addr;
  logic            surv_rd_en;
  logic [AW-1:0]   surv_rd_addr;
  logic [2**M-1:0] surv_rd_data;
  logic            dec_bit;
  logic            dec_valid;
  logic            dec_last;
  logic            busy;
  logic            overrun;

  modport master (
    input  acs_valid, min_state, surv_rd_data,
    output surv_wr_en, surv_wr_addr,
    output surv_rd_en, surv_rd_addr,
    output dec_bit, dec_valid, dec_last,
    output busy, overrun
  );

  modport slave (
    output acs_valid, min_state, surv_rd_data,
    input  surv_wr_en, surv_wr_addr,
    input  surv_rd_en, surv_rd_addr,
    input  dec_bit, dec_valid, dec_last,
    input  busy, overrun
  );
endinterface

// File: rtl/e_tb_ctrl_213.sv
// Traceback controller: circular survivor-memory pointers and block
// traceback sequencing; decoded bits leave newest-first.
module e_tb_ctrl_213 #(
  parameter int M        = 3,
  parameter int TB_DEPTH = 16,
  parameter int AW       = 6
) (
  input  logic            clk,
  input  logic            reset,
  e_tb_ctrl_213_if.master bus
);

  localparam int D2 = 2 * TB_DEPTH;
  localparam int FW = $clog2(D2 + 1);
  localparam int CW = $clog2(D2);
  localparam int BW = (TB_DEPTH > 1) ? $clog2(TB_DEPTH) : 1;

  localparam logic [FW-1:0] FILL_MAX = FW'(D2);
  localparam logic [FW-1:0] FILL_PRE = FW'(D2 - 1);
  localparam logic [BW-1:0] BLK_MAX  = BW'(TB_DEPTH - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(D2 - 1);
  localparam logic [CW-1:0] DEC_MIN  = CW'(TB_DEPTH);

  if ((2 ** AW) < 4 * TB_DEPTH) begin : g_depth_chk
    $fatal(1, "survivor memory too shallow for TB_DEPTH");
  end

  typedef enum logic [1:0] {
    IDLE,
    TRACE,
    DRAIN
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_ptr;
  logic [FW-1:0] fill;
  logic [BW-1:0] blk;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] rd_cnt;
  logic          ret_act;
  logic [CW-1:0] ret_k;
  logic [M-1:0]  ts;
  logic          ovr;

  logic fill_ok;
  logic blk_wrap;
  logic trig;
  logic busy_w;

  assign fill_ok  = fill >= FILL_PRE;
  assign blk_wrap = blk == BLK_MAX;
  assign trig     = bus.acs_valid && fill_ok && blk_wrap;
  assign busy_w   = state != IDLE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      fill    <= '0;
      blk     <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
      rd_cnt  <= '0;
      ret_act <= 1'b0;
      ret_k   <= '0;
      ts      <= '0;
      ovr     <= 1'b0;
    end else begin
      if (bus.acs_valid) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (fill != FILL_MAX) fill <= fill + 1'b1;
        blk <= blk_wrap ? '0 : blk + 1'b1;
      end
      if (trig && busy_w) ovr <= 1'b1;
      // data lands one cycle after each read strobe
      ret_act <= rd_en;
      if (ret_act) begin
        ts    <= {ts[M-2:0], bus.surv_rd_data[ts]};
        ret_k <= ret_k + 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (trig) begin
            state   <= TRACE;
            rd_en   <= 1'b1;
            rd_addr <= wr_ptr;
            rd_cnt  <= '0;
            ts      <= bus.min_state;
            ret_k   <= '0;
          end
        end
        TRACE: begin
          if (rd_cnt == CNT_MAX) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr - 1'b1;
            rd_cnt  <= rd_cnt + 1'b1;
          end
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.surv_wr_en   = bus.acs_valid;
  assign bus.surv_wr_addr = wr_ptr;
  assign bus.surv_rd_en   = rd_en;
  assign bus.surv_rd_addr = rd_addr;
  assign bus.dec_bit      = ts[M-1];
  assign bus.dec_valid    = ret_act && (ret_k >= DEC_MIN);
  assign bus.dec_last     = ret_act && (ret_k == CNT_MAX);
  assign bus.busy         = busy_w;
  assign bus.overrun      = ovr;

endmodule

// File: tb/tb_e_tb_ctrl_213.sv
// Bench for e_tb_ctrl_213: vector table, hand sequences and random traffic
// against a cycle-offset reference model of the traceback.
module tb_e_tb_ctrl_213;
  localparam int M  = 3;
  localparam int D  = 4;
  localparam int AW = 4;
  localparam int NA = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  e_tb_ctrl_213_if #(.M(M), .AW(AW)) bus ();

  e_tb_ctrl_213 #(.M(M), .TB_DEPTH(D), .AW(AW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  logic [7:0] mem [NA];
  logic [7:0] wdata;

  always @(posedge clk) begin
    if (bus.surv_wr_en) mem[bus.surv_wr_addr] <= wdata;
    if (bus.surv_rd_en) bus.surv_rd_data <= mem[bus.surv_rd_addr];
  end

  typedef struct {
    int         ival;
    int         n;
    logic [2:0] ms;
    logic [7:0] word;
    logic [3:0] bits;
    logic       ovr;
  } tvec_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int nw;
  int tacc;
  int start_m;
  logic [3:0] ebits;
  logic ovr_m;
  logic [7:0] mem_m [NA];
  logic [3:0] got_bits;
  int got_n;
  int nval;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    nw = 0;
    tacc = -1000;
    ovr_m = 1'b0;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      bus.acs_valid = 1'b0;
      bus.min_state = '0;
      wdata = '0;
      #1;
      if (i > 0) begin
        chk("rst_wr_en", 32'(bus.surv_wr_en), 0);
        chk("rst_wr_addr", 32'(bus.surv_wr_addr), 0);
        chk("rst_rd_en", 32'(bus.surv_rd_en), 0);
        chk("rst_rd_addr", 32'(bus.surv_rd_addr), 0);
        chk("rst_dec_bit", 32'(bus.dec_bit), 0);
        chk("rst_dec_valid", 32'(bus.dec_valid), 0);
        chk("rst_dec_last", 32'(bus.dec_last), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_overrun", 32'(bus.overrun), 0);
      end
      cyc++;
    end
    model_reset();
  endtask

  task automatic step(input logic av, input logic [2:0] ms,
                      input logic [7:0] w);
    int d;
    int ai;
    int ea;
    logic [2:0] ts;
    logic [7:0] wd;
    @(negedge clk);
    reset = 1'b0;
    bus.acs_valid = av;
    bus.min_state = ms;
    wdata = w;
    #1;
    d = cyc - tacc;
    chk("wr_en", 32'(bus.surv_wr_en), 32'(av));
    chk("wr_addr", 32'(bus.surv_wr_addr), 32'(nw % NA));
    chk("rd_en", 32'(bus.surv_rd_en), 32'(d >= 1 && d <= 2 * D));
    if (d >= 1 && d <= 2 * D) begin
      ea = ((start_m - (d - 1)) % NA + NA) % NA;
      chk("rd_addr", 32'(bus.surv_rd_addr), 32'(ea));
    end
    chk("busy", 32'(bus.busy), 32'(d >= 1 && d <= 2 * D + 1));
    chk("dec_valid", 32'(bus.dec_valid), 32'(d >= D + 2 && d <= 2 * D + 1));
    chk("dec_last", 32'(bus.dec_last), 32'(d == 2 * D + 1));
    if (d >= D + 2 && d <= 2 * D + 1)
      chk("dec_bit", 32'(bus.dec_bit), 32'(ebits[d - D - 2]));
    chk("overrun", 32'(bus.overrun), 32'(ovr_m));
    if (bus.dec_valid === 1'b1) begin
      nval++;
      if (got_n < 4) begin
        got_bits[got_n] = bus.dec_bit;
        got_n++;
      end
    end
    if (av) begin
      ai = nw % NA;
      mem_m[ai] = w;
      nw++;
      if (nw >= 2 * D && nw % D == 0) begin
        if (d >= 1 && d <= 2 * D + 1) ovr_m = 1'b1;
        else begin
          tacc = cyc;
          start_m = ai;
          ts = ms;
          for (int k = 0; k < 2 * D; k++) begin
            wd = mem_m[(ai - k + NA) % NA];
            if (k >= D) ebits[k - D] = ts[2];
            ts = {ts[1:0], wd[ts]};
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 8'h00);
  endtask

  task automatic clr_obs();
    got_n = 0;
    got_bits = '0;
    nval = 0;
  endtask

  tvec_t tv [6];
  int pct;

  initial begin
    tv[0] = '{3, 8, 3'd0, 8'h00, 4'b0000, 1'b0};
    tv[1] = '{3, 8, 3'd7, 8'hFF, 4'b1111, 1'b0};
    tv[2] = '{3, 8, 3'd0, 8'h0F, 4'b0011, 1'b0};
    tv[3] = '{3, 8, 3'd7, 8'h0F, 4'b1100, 1'b0};
    tv[4] = '{3, 20, 3'd0, 8'h00, 4'b0000, 1'b0};
    tv[5] = '{1, 16, 3'd7, 8'hFF, 4'b1111, 1'b1};

    bus.acs_valid = 1'b0;
    bus.min_state = '0;
    wdata = '0;
    model_reset();
    clr_obs();

    for (int t = 0; t < 6; t++) begin
      do_reset(2);
      clr_obs();
      for (int i = 0; i < tv[t].n; i++) begin
        step(1'b1, tv[t].ms, tv[t].word);
        idle(tv[t].ival - 1);
      end
      idle(12);
      chk("tbl_bits", 32'(got_bits), 32'(tv[t].bits));
      chk("tbl_ovr", 32'(bus.overrun), 32'(tv[t].ovr));
    end

    // path tracking with distinct words at the newest two addresses
    do_reset(2);
    clr_obs();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 7) ? 3'd1 : 3'd0,
           (i == 6) ? 8'h08 : (i == 7) ? 8'h02 : 8'h00);
      idle(1);
    end
    idle(12);
    chk("path_bits", 32'(got_bits), 32'b0001);

    // reset in the middle of a traceback
    do_reset(2);
    clr_obs();
    for (int i = 0; i < 8; i++) step(1'b1, 3'd2, 8'h55);
    idle(3);
    do_reset(1);
    clr_obs();
    idle(12);
    chk("abort_nodec", 32'(nval), 0);

    // trigger landing in the drain cycle is dropped
    do_reset(2);
    clr_obs();
    for (int i = 0; i < 8; i++) step(1'b1, 3'd0, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 8'hA5);
    idle(5);
    step(1'b1, 3'd0, 8'hA5);
    idle(12);
    chk("drain_ovr", 32'(bus.overrun), 1);
    chk("drain_blocks", 32'(nval), 4);

    // one cycle later it is accepted
    do_reset(2);
    clr_obs();
    for (int i = 0; i < 8; i++) step(1'b1, 3'd0, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b1, 3'd0, 8'hA5);
    idle(6);
    step(1'b1, 3'd4, 8'h3C);
    idle(12);
    chk("after_ovr", 32'(bus.overrun), 0);
    chk("after_blocks", 32'(nval), 8);

    // random traffic with varying write density
    do_reset(2);
    clr_obs();
    for (int i = 0; i < 800; i++) begin
      case ((i / 100) % 4)
        0: pct = 100;
        1: pct = 40;
        2: pct = 25;
        default: pct = 15;
      endcase
      step(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0,
           3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
    end
    idle(12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
